regfile_scan_checker: RTL

//  Self-checking end-of-run stage sitting beside the processor and regfile.
//  - Counts a programmable number of run cycles and the committed register writes in that window.
//  - Then takes over regfile read port A and scans every register.
//  - Compares each register against an expected-value ROM and reports pass/fail per register

---
 rtl/regfile_scan_checker_if.sv | 54 +++++
 rtl/regfile_scan_checker.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/regfile_scan_checker_if.sv
// ----------------------------------------------------------------------------
// regfile_scan_checker_if
//   Bundles every non-clock/reset signal of regfile_scan_checker.
//   slave  : the checker itself (consumes start/processor/regfile/ROM inputs,
//            drives the regfile read mux, ROM address and status outputs)
//   master : the surrounding system (processor, regfile, ROM, run control)
//
//   start        1-cycle run+scan request
//   num_cycles   run length, latched on accepted start
//   rwe/rd       processor write-port enable and destination index
//   proc_rs1     processor read-port A index
//   rs1_out      regfile read-port A index (scan index while scanning)
//   regA         regfile read-port A data (combinational from rs1_out)
//   exp_addr     expected-value ROM address
//   exp_data     expected-value ROM data, one cycle after exp_addr
//   busy/done/pass, error_count, write_count, fail_* : status and results
// ----------------------------------------------------------------------------
interface regfile_scan_checker_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32,
    parameter int CYC_W  = 8,
    parameter int WCNT_W = 16
);
    logic              start;
    logic [CYC_W-1:0]  num_cycles;
    logic              rwe;
    logic [ADDR_W-1:0] rd;
    logic [ADDR_W-1:0] proc_rs1;
    logic [ADDR_W-1:0] rs1_out;
    logic [DATA_W-1:0] regA;
    logic [ADDR_W-1:0] exp_addr;
    logic [DATA_W-1:0] exp_data;
    logic              busy;
    logic              done;
    logic              pass;
    logic [ADDR_W:0]   error_count;
    logic [WCNT_W-1:0] write_count;
    logic              fail_valid;
    logic [ADDR_W-1:0] fail_reg;
    logic [DATA_W-1:0] fail_exp;
    logic [DATA_W-1:0] fail_act;

    modport slave (
        input  start, num_cycles, rwe, rd, proc_rs1, regA, exp_data,
        output rs1_out, exp_addr, busy, done, pass, error_count, write_count,
               fail_valid, fail_reg, fail_exp, fail_act
    );

    modport master (
        output start, num_cycles, rwe, rd, proc_rs1, regA, exp_data,
        input  rs1_out, exp_addr, busy, done, pass, error_count, write_count,
               fail_valid, fail_reg, fail_exp, fail_act
    );
endinterface

// File: rtl/regfile_scan_checker.sv
// ----------------------------------------------------------------------------
// regfile_scan_checker
//   End-of-run self-check stage. After an accepted start it counts num_cycles
//   run cycles (tallying committed register writes), then takes over regfile
//   read port A, scans every register and compares it with an expected-value
//   ROM, reporting each mismatch and a final pass/fail summary.
//
//   Ports:
//     clock  sole clock, rising edge
//     reset  synchronous, active-high, clears all state
//     bus    regfile_scan_checker_if.slave (run control, processor write and
//            read ports, regfile read port A, expected ROM, status/results)
//
//   Build option:
//     REGSCAN_STOP_ON_FAIL_EN  when defined, the first mismatch ends the scan
//                              (error_count is then 0 or 1); when undefined
//                              every register is scanned and every mismatch
//                              is counted.
// ----------------------------------------------------------------------------
module regfile_scan_checker #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32,
    parameter int CYC_W    = 8,
    parameter int WCNT_W   = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    regfile_scan_checker_if.slave   bus
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_SCAN  = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    logic [1:0]        state_q,      state_d;
    logic [CYC_W-1:0]  run_cnt_q,    run_cnt_d;
    logic [ADDR_W-1:0] scan_idx_q,   scan_idx_d;
    logic              cmp_vld_q,    cmp_vld_d;
    logic [ADDR_W-1:0] cmp_idx_q,    cmp_idx_d;
    logic [DATA_W-1:0] act_q,        act_d;
    logic              done_q,       done_d;
    logic [ADDR_W:0]   err_cnt_q,    err_cnt_d;
    logic [WCNT_W-1:0] wr_cnt_q,     wr_cnt_d;
    logic              fail_valid_q, fail_valid_d;
    logic [ADDR_W-1:0] fail_reg_q,   fail_reg_d;
    logic [DATA_W-1:0] fail_exp_q,   fail_exp_d;
    logic [DATA_W-1:0] fail_act_q,   fail_act_d;

    logic mismatch;

    // Write counter holds at all-ones instead of wrapping.
    function automatic logic [WCNT_W-1:0] sat_inc(input logic [WCNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // The ROM answers one cycle after its address, so the register value read
    // in the same cycle is held in act_q and compared one cycle later. The
    // 4-state compare makes an X/Z register read count as a mismatch.
    assign mismatch = cmp_vld_q && (act_q !== bus.exp_data);

    always_comb begin
        state_d      = state_q;
        run_cnt_d    = run_cnt_q;
        scan_idx_d   = scan_idx_q;
        cmp_vld_d    = 1'b0;
        cmp_idx_d    = cmp_idx_q;
        act_d        = act_q;
        done_d       = done_q;
        err_cnt_d    = err_cnt_q;
        wr_cnt_d     = wr_cnt_q;
        fail_valid_d = 1'b0;
        fail_reg_d   = fail_reg_q;
        fail_exp_d   = fail_exp_q;
        fail_act_d   = fail_act_q;

        if (mismatch) begin
            err_cnt_d    = err_cnt_q + 1'b1;
            fail_valid_d = 1'b1;
            fail_reg_d   = cmp_idx_q;
            fail_exp_d   = bus.exp_data;
            fail_act_d   = act_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    done_d     = 1'b0;
                    err_cnt_d  = '0;
                    wr_cnt_d   = '0;
                    fail_reg_d = '0;
                    fail_exp_d = '0;
                    fail_act_d = '0;
                    run_cnt_d  = bus.num_cycles;
                    scan_idx_d = '0;
                    state_d    = (bus.num_cycles == '0) ? ST_SCAN : ST_RUN;
                end
            end
            ST_RUN: begin
                if (bus.rwe && (bus.rd != '0)) begin
                    wr_cnt_d = sat_inc(wr_cnt_q);
                end
                run_cnt_d = run_cnt_q - 1'b1;
                if (run_cnt_q == CYC_W'(1)) begin
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                act_d     = bus.regA;
                cmp_vld_d = 1'b1;
                cmp_idx_d = scan_idx_q;
                if (scan_idx_q == LAST_IDX) begin
                    scan_idx_d = '0;
                    state_d    = ST_DRAIN;
                end else begin
                    scan_idx_d = scan_idx_q + 1'b1;
                end
`ifdef REGSCAN_STOP_ON_FAIL_EN
                // Abandon the scan; the register read this cycle is dropped.
                if (mismatch) begin
                    cmp_vld_d  = 1'b0;
                    scan_idx_d = '0;
                    done_d     = 1'b1;
                    state_d    = ST_IDLE;
                end
`endif
            end
            default: begin
                // DRAIN: the last register's compare happens here.
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            run_cnt_q    <= '0;
            scan_idx_q   <= '0;
            cmp_vld_q    <= 1'b0;
            cmp_idx_q    <= '0;
            act_q        <= '0;
            done_q       <= 1'b0;
            err_cnt_q    <= '0;
            wr_cnt_q     <= '0;
            fail_valid_q <= 1'b0;
            fail_reg_q   <= '0;
            fail_exp_q   <= '0;
            fail_act_q   <= '0;
        end else begin
            state_q      <= state_d;
            run_cnt_q    <= run_cnt_d;
            scan_idx_q   <= scan_idx_d;
            cmp_vld_q    <= cmp_vld_d;
            cmp_idx_q    <= cmp_idx_d;
            act_q        <= act_d;
            done_q       <= done_d;
            err_cnt_q    <= err_cnt_d;
            wr_cnt_q     <= wr_cnt_d;
            fail_valid_q <= fail_valid_d;
            fail_reg_q   <= fail_reg_d;
            fail_exp_q   <= fail_exp_d;
            fail_act_q   <= fail_act_d;
        end
    end

    // Read port A belongs to the processor except while scanning.
    assign bus.rs1_out     = (state_q == ST_SCAN) ? scan_idx_q : bus.proc_rs1;
    assign bus.exp_addr    = scan_idx_q;
    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.done        = done_q;
    assign bus.pass        = done_q && (err_cnt_q == '0);
    assign bus.error_count = err_cnt_q;
    assign bus.write_count = wr_cnt_q;
    assign bus.fail_valid  = fail_valid_q;
    assign bus.fail_reg    = fail_reg_q;
    assign bus.fail_exp    = fail_exp_q;
    assign bus.fail_act    = fail_act_q;

endmodule
